// File: rtl/piso_bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_bit_serializer_if
//  Purpose  : Load handshake and serial output bundle for piso_bit_serializer.
//  Signals  : data_in    [WIDTH] parallel word offered by the source
//             load_valid          data_in is valid
//             load_ready          serializer can take a word this cycle
//             ser_out             serial bit to the downstream detector
//             ser_valid           ser_out carries a data bit (0 = idle fill)
//             last                final bit of a word is on ser_out
//             busy                shifter active or holding register full
//  Modports : master = word source / bit sink, slave = serializer
//  Revision : 1.0  initial release
// ============================================================================
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             last;
  logic             busy;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output ser_out,
    output ser_valid,
    output last,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/piso_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_bit_serializer
//  Purpose  : Parallel-in / serial-out stage with a one-word holding register.
//             Words stream back to back with no gap bits; while nothing is
//             being shifted the serial line carries IDLE_BIT.
//  Ports    : clk    rising-edge clock
//             reset  asynchronous active-low reset (0 = reset)
//             bus    piso_bit_serializer_if.slave (handshake + serial output)
//  Params   : WIDTH (>=2), MSB_FIRST (1 = bit WIDTH-1 first), IDLE_BIT
//  Revision : 1.0  initial release
// ============================================================================
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  piso_bit_serializer_if.slave   bus
);

  localparam int                 C_CNT_W = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift_reg;
  logic [C_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_hold_reg;
  logic               r_hold_full;

  logic               w_accept;
  logic               w_out_bit;
  logic [WIDTH-1:0]   w_shift_next;
  logic               w_ser_valid;

  // The hold register is the only thing that can refuse a word: the shifter
  // itself never back-pressures because an accepted word either bypasses
  // into it or parks in the hold register.
  assign w_accept = bus.load_valid && !r_hold_full;

  // Output end of the shift register and the value after one shift step.
  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit    = r_shift_reg[WIDTH-1];
    assign w_shift_next = {r_shift_reg[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_out_bit    = r_shift_reg[0];
    assign w_shift_next = {1'b0, r_shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_hold_reg  <= '0;
      r_hold_full <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (r_bit_cnt < C_LAST) begin
        // Mid-word: keep shifting, park any new word in the hold register.
        r_shift_reg <= w_shift_next;
        r_bit_cnt   <= r_bit_cnt + C_ONE;
        if (w_accept) begin
          r_hold_reg  <= bus.data_in;
          r_hold_full <= 1'b1;
        end
      end else if (r_bit_cnt == C_LAST) begin
        // Final bit on the line: chain the next word in without a gap.
        // A held word has priority; load_ready is low while it is held, so
        // no new word can arrive on the same edge.
        r_bit_cnt <= '0;
        if (r_hold_full) begin
          r_shift_reg <= r_hold_reg;
          r_hold_full <= 1'b0;
        end else if (w_accept) begin
          r_shift_reg <= bus.data_in;
        end else begin
          r_state <= ST_IDLE;
        end
      end else begin
        // Counter encodings beyond WIDTH-1 only exist for non-power-of-2
        // widths; recover to IDLE and keep any accepted word.
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        if (w_accept) begin
          r_hold_reg  <= bus.data_in;
          r_hold_full <= 1'b1;
        end
      end
    end else begin
      // IDLE: a word left in the hold register (only after counter
      // recovery) goes first, otherwise a new word bypasses straight in.
      r_bit_cnt <= '0;
      if (r_hold_full) begin
        r_shift_reg <= r_hold_reg;
        r_hold_full <= 1'b0;
        r_state     <= ST_SHIFT;
      end else if (w_accept) begin
        r_shift_reg <= bus.data_in;
        r_state     <= ST_SHIFT;
      end
    end
  end

  // All outputs decode registered state only.
  assign w_ser_valid    = (r_state == ST_SHIFT);
  assign bus.ser_valid  = w_ser_valid;
  assign bus.ser_out    = w_ser_valid ? w_out_bit : IDLE_BIT;
  assign bus.last       = w_ser_valid && (r_bit_cnt == C_LAST);
  assign bus.busy       = w_ser_valid || r_hold_full;
  assign bus.load_ready = !r_hold_full;

endmodule
`default_nettype wire
